// File: rtl/mandel_iter.sv
// mandel_iter: per-pixel Mandelbrot escape-time engine, one z <- z^2 + c step per clock.
// Ports: clk, rst (async, active-high); start/x0/y0/max_iter form the request, sampled only when idle;
//        busy while iterating; done pulses one cycle; iter/escaped hold the last result until the next finish.
module mandel_iter #(
  parameter int BITS      = 16,
  parameter int ITER_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BITS-1:0]      x0,
  input  logic [BITS-2:0]      y0,
  input  logic [ITER_BITS-1:0] max_iter,
  output logic                 busy,
  output logic                 done,
  output logic [ITER_BITS-1:0] iter,
  output logic                 escaped
);

  localparam int F  = BITS - 3;   // fractional bits
  localparam int W  = BITS + 2;   // internal z/c width: 5 integer bits
  localparam int PW = 2 * W;      // full product width

  // |z|^2 escape threshold, 4.0 in the product-aligned format
  localparam logic signed [PW-1:0] ESC_LIMIT = PW'(4) << F;

  typedef enum logic {IDLE, ITER} state_t;

  state_t                state;
  logic signed [W-1:0]   z_x, z_y, c_x, c_y;
  logic [ITER_BITS-1:0]  count, limit;

  // Operands sign-extended to the product width so the products are exact
  logic signed [PW-1:0]  zx_e, zy_e, cx_e, cy_e;
  logic signed [PW-1:0]  xx, yy, xy2, mag;

  assign zx_e = $signed({{W{z_x[W-1]}}, z_x});
  assign zy_e = $signed({{W{z_y[W-1]}}, z_y});
  assign cx_e = $signed({{W{c_x[W-1]}}, c_x});
  assign cy_e = $signed({{W{c_y[W-1]}}, c_y});

  // Floor-shifted products back to F fractional bits; xy2 folds in the factor of two
  assign xx  = (zx_e * zx_e) >>> F;
  assign yy  = (zy_e * zy_e) >>> F;
  assign xy2 = (zx_e * zy_e) >>> (F - 1);
  // Kept at full product width so the magnitude compare can never wrap
  assign mag = xx + yy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      iter    <= '0;
      escaped <= 1'b0;
      z_x     <= '0;
      z_y     <= '0;
      c_x     <= '0;
      c_y     <= '0;
      count   <= '0;
      limit   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            c_x   <= {{2{x0[BITS-1]}}, x0};
            c_y   <= {{3{y0[BITS-2]}}, y0};
            limit <= max_iter;
            z_x   <= '0;
            z_y   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          if (mag >= ESC_LIMIT) begin
            iter    <= count;
            escaped <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (count == limit) begin
            // Limit is checked before the increment, so count never wraps
            iter    <= count;
            escaped <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            // Results fit in W bits whenever this branch is taken (|z|<2, |c|<4)
            z_x   <= W'(xx - yy + cx_e);
            z_y   <= W'(xy2 + cy_e);
            count <= count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter.sv
module tb_mandel_iter;

  localparam int BITS      = 16;
  localparam int ITER_BITS = 8;
  localparam int F         = BITS - 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [BITS-1:0]      x0 = '0;
  logic [BITS-2:0]      y0 = '0;
  logic [ITER_BITS-1:0] max_iter = '0;
  logic                 busy, done, escaped;
  logic [ITER_BITS-1:0] iter;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    int k;     // edge number at which start was accepted
    int it;
    bit esc;
  } exp_t;

  exp_t sb[$];

  mandel_iter #(.BITS(BITS), .ITER_BITS(ITER_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .max_iter(max_iter),
    .busy(busy), .done(done), .iter(iter), .escaped(escaped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Escape-time reference: plain integer arithmetic on real fixed-point values
  function automatic void model(input int cx, input int cy, input int m,
                                output int it, output bit esc);
    longint zx, zy, xx, yy, xy2;
    int     n;
    bit     fin;
    zx = 0; zy = 0; n = 0; fin = 0; it = 0; esc = 0;
    while (!fin) begin
      xx  = (zx * zx) >>> F;
      yy  = (zy * zy) >>> F;
      xy2 = (zx * zy) >>> (F - 1);
      if (xx + yy >= (longint'(4) << F)) begin
        it = n; esc = 1; fin = 1;
      end else if (n == m) begin
        it = n; esc = 0; fin = 1;
      end else begin
        zx = xx - yy + cx;
        zy = xy2 + cy;
        n++;
      end
    end
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // it_exp < 0 selects the reference model; push=0 issues a pixel with no expected result
  task automatic issue(input logic [BITS-1:0] x, input logic [BITS-2:0] y,
                       input logic [ITER_BITS-1:0] m, input int it_exp, input bit esc_exp,
                       input bit push);
    exp_t e;
    int   mi;
    bit   me;
    @(negedge clk);
    wait_idle();
    x0 = x; y0 = y; max_iter = m; start = 1'b1;
    e.k = cyc + 1;
    if (it_exp < 0) begin
      model(int'($signed(x)), int'($signed(y)), int'(m), mi, me);
      e.it = mi; e.esc = me;
    end else begin
      e.it = it_exp; e.esc = esc_exp;
    end
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Inputs may change freely once the start edge has passed
    x0 = BITS'($urandom);
    y0 = (BITS-1)'($urandom);
    max_iter = ITER_BITS'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest expected result, including its timing
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("iter", 64'(iter), 64'(e.it));
          check("escaped", 64'(escaped), 64'(e.esc));
          check("latency", 64'(cyc - e.k), 64'(e.it + 1));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    int bc;
    int t;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_iter", 64'(iter), 64'd0);
    check("rst_escaped", 64'(escaped), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // c=(0,0), limit 15: never escapes, busy for 16 cycles
    issue(16'h0000, 15'h0000, 8'd15, 15, 1'b0, 1'b1);
    bc = 0; t = 0;
    while (busy === 1'b1 && t < 100) begin
      bc++;
      @(negedge clk);
      t++;
    end
    check("busy_cycles", 64'(bc), 64'd16);

    // +/-2.0 on the real axis escape at iteration 1; (1,1) escapes at iteration 2
    issue(16'h4000, 15'h0000, 8'd255, 1, 1'b1, 1'b1);
    issue(16'hC000, 15'h0000, 8'd255, 1, 1'b1, 1'b1);
    issue(16'h2000, 15'h2000, 8'd255, 2, 1'b1, 1'b1);

    // Zero limit finishes in the first iteration cycle
    issue(16'h2000, 15'h2000, 8'd0, 0, 1'b0, 1'b1);
    issue(16'h4000, 15'h0000, 8'd0, 0, 1'b0, 1'b1);

    // A start pulse while busy must not re-latch the inputs
    issue(16'h0000, 15'h0000, 8'd15, 15, 1'b0, 1'b1);
    x0 = 16'h4000; y0 = 15'h0000; max_iter = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held high across done: second pixel accepted in the done cycle
    @(negedge clk);
    wait_idle();
    begin
      exp_t e1, e2;
      x0 = 16'h4000; y0 = 15'h0000; max_iter = 8'd255; start = 1'b1;
      e1.k = cyc + 1; e1.it = 1; e1.esc = 1'b1;
      e2.k = cyc + 4; e2.it = 2; e2.esc = 1'b1;
      sb.push_back(e1);
      sb.push_back(e2);
      @(negedge clk);
      x0 = 16'h2000; y0 = 15'h2000;
      t = 0;
      while (done !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      check("b2b_accept_busy", 64'(busy), 64'd1);
      start = 1'b0;
    end

    // Reset mid-iteration: outputs clear immediately and the aborted pixel never reports
    issue(16'h0000, 15'h0000, 8'd100, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_iter", 64'(iter), 64'd0);
    check("abort_escaped", 64'(escaped), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (110) @(negedge clk);
    check("abort_pending", 64'(sb.size()), 64'd0);
    issue(16'h2000, 15'h2000, 8'd255, 2, 1'b1, 1'b1);

    // Randomized pixels against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [ITER_BITS-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? 8'd255 : ITER_BITS'($urandom_range(0, 40));
      issue(BITS'($urandom), (BITS-1)'($urandom), m, -1, 1'b0, 1'b1);
    end
    // Random points inside the main cardioid region exercise the limit path
    for (int i = 0; i < 20; i++) begin
      issue(BITS'($urandom_range(0, 16'h0FFF)) - 16'h0800,
            (BITS-1)'($urandom_range(0, 15'h0FFF)) - 15'h0800,
            ITER_BITS'($urandom_range(0, 60)), -1, 1'b0, 1'b1);
    end

    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
